// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: request size encodings (RISC-V funct3),
// responder FSM states and the wait-state counter width.
package dmem_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic size_is_legal(input logic [2:0] size);
        case (size)
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: size_is_legal = 1'b1;
            default:                        size_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for 32-bit memory words: store byte enables and replicated data,
// load lane selection with sign/zero extension, plus misalignment and illegal-size flags.
module dmem_lane
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      size,
    input  logic [1:0]      addr_lo,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rword,
    output logic [3:0]      byte_en,
    output logic [31:0]     wdata_lanes,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misalign,
    output logic            bad_size
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte = rword[{addr_lo, 3'b000} +: 8];
        rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    // Halfword/word selection ignores the low address bits, which gives the
    // align-down behaviour for free; the misalign flag reports them separately.
    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = 32'h0;
        rdata_ext   = '0;
        misalign    = 1'b0;
        bad_size    = !size_is_legal(size);
        case (size)
            SZ_B, SZ_BU: begin
                byte_en     = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = (size == SZ_B) ? XLEN'($signed(rbyte)) : XLEN'(rbyte);
            end
            SZ_H, SZ_HU: begin
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = (size == SZ_H) ? XLEN'($signed(rhalf)) : XLEN'(rhalf);
                misalign    = addr_lo[0];
            end
            default: begin
                byte_en     = 4'b1111;
                wdata_lanes = wdata;
                rdata_ext   = XLEN'(rword);
                misalign    = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store slave with programmable wait states and a
// byte-lane word array. Define DMEM_ERR_EN to reject misaligned and illegal-size requests.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_size,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

    state_e                  state_reg;
    logic [WAIT_CNT_W-1:0]   cnt_reg;
    logic                    we_reg;
    logic [IDX_W+1:0]        addr_reg;
    logic [31:0]             wdata_reg;
    logic [2:0]              size_reg;
    logic                    req_ready_reg;
    logic                    rsp_valid_reg;
    logic                    rsp_err_reg;
    logic                    rsp_load_reg;

    logic [IDX_W-1:0]        word_idx;
    logic [3:0]              byte_en;
    logic [31:0]             wdata_lanes;
    logic [31:0]             rword;
    logic [XLEN-1:0]         rdata_ext;
    logic                    misalign;
    logic                    bad_size;
    logic                    reject;
    logic                    commit;

    logic                    unused_addr;
    assign unused_addr = ^req_addr[XLEN-1:IDX_W+2];

    assign word_idx = addr_reg[IDX_W+1:2];

    dmem_lane #(
        .XLEN (XLEN)
    ) u_lane (
        .size        (size_reg),
        .addr_lo     (addr_reg[1:0]),
        .wdata       (wdata_reg),
        .rword       (rword),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext),
        .misalign    (misalign),
        .bad_size    (bad_size)
    );

`ifdef DMEM_ERR_EN
    assign reject = misalign | bad_size;
`else
    logic unused_flags;
    assign unused_flags = misalign ^ bad_size;
    assign reject       = 1'b0;
`endif

    // The array access happens on the BUSY->RESP edge. Because the state is reset
    // asynchronously, a reset during BUSY also removes the pending commit.
    assign commit = (state_reg == BUSY) && (cnt_reg == '0);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_reg;

            always_ff @(posedge clk) begin
                if (commit && we_reg && !reject && byte_en[gi]) begin
                    mem[word_idx] <= wdata_lanes[gi*8 +: 8];
                end
                if (commit && !we_reg) begin
                    rd_reg <= mem[word_idx];
                end
            end

            assign rword[gi*8 +: 8] = rd_reg;
        end
    endgenerate

    // A zero wait-state request still spends one cycle in BUSY so the array sees
    // registered request fields; response latency is therefore WAIT_CYCLES+1 edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= 32'h0;
            size_reg      <= 3'b000;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_load_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg        <= req_we;
                        addr_reg      <= req_addr[IDX_W+1:0];
                        wdata_reg     <= req_wdata[31:0];
                        size_reg      <= req_size;
                        cnt_reg       <= WAIT_INIT;
                        req_ready_reg <= 1'b0;
                        state_reg     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= reject;
                        rsp_load_reg  <= !we_reg && !reject;
                        state_reg     <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                        rsp_load_reg  <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    rsp_err_reg   <= 1'b0;
                    rsp_load_reg  <= 1'b0;
                    req_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_load_reg ? rdata_ext : '0;

endmodule
